// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the gated SR latch driver.
package sr_drv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        CHECK,
        DONE
    } state_e;

    localparam logic OP_RESET = 1'b0;
    localparam logic OP_SET   = 1'b1;

    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/sr_latch_driver_sync2.sv
// Two-flop synchroniser for the asynchronous latch Q feedback; resets to 0.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/sr_latch_driver.sv
// Sequences gate/set/reset pins of a gated SR latch with setup/pulse/hold timing
// and verifies the latch state through a synchronised Q readback.
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    input  logic                 req_op,
    output logic                 req_ready,
    output logic                 lat_g,
    output logic                 lat_s,
    output logic                 lat_r,
    input  logic                 lat_q,
    output logic                 done_valid,
    output logic                 done_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam longint CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    if (SETUP_CYC < 1 || longint'(SETUP_CYC) > CNT_MAX) begin : g_bad_setup
        $error("SETUP_CYC must be in 1..2**CNT_W-1");
    end
    if (PULSE_CYC < 1 || longint'(PULSE_CYC) > CNT_MAX) begin : g_bad_pulse
        $error("PULSE_CYC must be in 1..2**CNT_W-1");
    end
    if (HOLD_CYC < 1 || longint'(HOLD_CYC) > CNT_MAX) begin : g_bad_hold
        $error("HOLD_CYC must be in 1..2**CNT_W-1");
    end

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 op_q, op_d;
    logic                 req_ready_q, req_ready_d;
    logic                 lat_g_q, lat_g_d;
    logic                 lat_s_q, lat_s_d;
    logic                 lat_r_q, lat_r_d;
    logic                 done_valid_q, done_valid_d;
    logic                 done_err_q, done_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 q_sync;
    logic                 cnt_zero;

    sync2 u_sync_q (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (lat_q),
        .q     (q_sync)
    );

    assign cnt_zero = (cnt_q == '0);

    // One down-counter times every phase; it is reloaded on each phase exit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = SETUP;
                    cnt_d   = CNT_W'(SETUP_CYC - 1);
                    op_d    = req_op;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_d = PULSE;
                    cnt_d   = CNT_W'(PULSE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PULSE: begin
                if (cnt_zero) begin
                    state_d = HOLD;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    state_d = CHECK;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CHECK: begin
                if (cnt_zero) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every pin leaves a flop.
    always_comb begin
        req_ready_d  = (state_d == IDLE);
        lat_g_d      = (state_d == PULSE);
        lat_s_d      = (state_d inside {SETUP, PULSE, HOLD}) && (op_d == OP_SET);
        lat_r_d      = (state_d inside {SETUP, PULSE, HOLD}) && (op_d == OP_RESET);
        done_valid_d = (state_d == DONE);
        done_err_d   = (state_d == DONE) && (q_sync != op_d);
        err_cnt_d    = err_cnt_q;
        if (done_err_d && err_cnt_q != ERR_CNT_MAX) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op_q         <= OP_RESET;
            req_ready_q  <= 1'b1;
            lat_g_q      <= 1'b0;
            lat_s_q      <= 1'b0;
            lat_r_q      <= 1'b0;
            done_valid_q <= 1'b0;
            done_err_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            req_ready_q  <= req_ready_d;
            lat_g_q      <= lat_g_d;
            lat_s_q      <= lat_s_d;
            lat_r_q      <= lat_r_d;
            done_valid_q <= done_valid_d;
            done_err_q   <= done_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign lat_g      = lat_g_q;
    assign lat_s      = lat_s_q;
    assign lat_r      = lat_r_q;
    assign done_valid = done_valid_q;
    assign done_err   = done_err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: two instances (default and 2/3/2 timing) driving
// behavioural gated SR latches, with a queue-based done scoreboard.
module tb_sr_latch_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;

    logic       req_valid_a, req_op_a, req_ready_a, lat_g_a, lat_s_a, lat_r_a, lat_q_a;
    logic       done_valid_a, done_err_a;
    logic [7:0] err_cnt_a;
    logic       req_valid_b, req_op_b, req_ready_b, lat_g_b, lat_s_b, lat_r_b, lat_q_b;
    logic       done_valid_b, done_err_b;
    logic [7:0] err_cnt_b;

    logic q_a = 1'b0;
    logic q_b = 1'b0;
    logic stuck = 1'b0;

    int n_checks = 0;
    int n_pass = 0;
    int excl_viol = 0;
    int cnt_model_a = 0;

    logic exp_err_a[$];
    int   exp_cnt_a[$];
    logic exp_err_b[$];

    sr_latch_driver dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_op(req_op_a),
        .req_ready(req_ready_a), .lat_g(lat_g_a), .lat_s(lat_s_a), .lat_r(lat_r_a),
        .lat_q(lat_q_a), .done_valid(done_valid_a), .done_err(done_err_a), .err_cnt(err_cnt_a)
    );

    sr_latch_driver #(.SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_op(req_op_b),
        .req_ready(req_ready_b), .lat_g(lat_g_b), .lat_s(lat_s_b), .lat_r(lat_r_b),
        .lat_q(lat_q_b), .done_valid(done_valid_b), .done_err(done_err_b), .err_cnt(err_cnt_b)
    );

    // Behavioural gated SR latches; latch A can be forced stuck at 0.
    always @(lat_g_a or lat_s_a or lat_r_a) begin
        if (lat_g_a) begin
            if (lat_s_a) q_a = 1'b1;
            else if (lat_r_a) q_a = 1'b0;
        end
    end
    always @(lat_g_b or lat_s_b or lat_r_b) begin
        if (lat_g_b) begin
            if (lat_s_b) q_b = 1'b1;
            else if (lat_r_b) q_b = 1'b0;
        end
    end
    assign lat_q_a = stuck ? 1'b0 : q_a;
    assign lat_q_b = q_b;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // S&R exclusivity and G-vs-S/R same-edge changes, sampled every cycle.
    logic pg_a = 1'b0, ps_a = 1'b0, pr_a = 1'b0;
    logic pg_b = 1'b0, ps_b = 1'b0, pr_b = 1'b0;
    logic prst = 1'b0;
    always @(negedge clk) begin
        if (rst_n && prst) begin
            if (lat_s_a && lat_r_a) excl_viol++;
            if (lat_s_b && lat_r_b) excl_viol++;
            if (lat_g_a != pg_a && (lat_s_a != ps_a || lat_r_a != pr_a)) excl_viol++;
            if (lat_g_b != pg_b && (lat_s_b != ps_b || lat_r_b != pr_b)) excl_viol++;
        end
        pg_a <= lat_g_a; ps_a <= lat_s_a; pr_a <= lat_r_a;
        pg_b <= lat_g_b; ps_b <= lat_s_b; pr_b <= lat_r_b;
        prst <= rst_n;
    end

    // Scoreboard monitors: pop one expectation per done_valid pulse.
    always @(negedge clk) begin
        if (rst_n && done_valid_a) begin
            if (exp_err_a.size() == 0) check("unexpected_done_a", 1, 0);
            else begin
                check("done_err_a", int'(done_err_a), int'(exp_err_a.pop_front()));
                check("err_cnt_a", int'(err_cnt_a), exp_cnt_a.pop_front());
            end
        end
        if (rst_n && done_valid_b) begin
            if (exp_err_b.size() == 0) check("unexpected_done_b", 1, 0);
            else begin
                check("done_err_b", int'(done_err_b), int'(exp_err_b.pop_front()));
                check("err_cnt_b", int'(err_cnt_b), 0);
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue_a(input logic op, input logic err);
        int n = 0;
        req_valid_a = 1'b1;
        req_op_a = op;
        while (!req_ready_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_timeout_a", 0, 1);
        else begin
            if (err && cnt_model_a < 255) cnt_model_a++;
            exp_err_a.push_back(err);
            exp_cnt_a.push_back(cnt_model_a);
        end
        @(negedge clk);
        req_valid_a = 1'b0;
    endtask

    task automatic issue_b(input logic op);
        int n = 0;
        req_valid_b = 1'b1;
        req_op_b = op;
        while (!req_ready_b && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_timeout_b", 0, 1);
        else exp_err_b.push_back(1'b0);
        @(negedge clk);
        req_valid_b = 1'b0;
    endtask

    task automatic drain_a();
        int n = 0;
        while ((exp_err_a.size() != 0 || !req_ready_a) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("drain_timeout_a", 0, 1);
    endtask

    // Cycle-by-cycle profile for the 2/3/2 instance; cycle c follows edge k+c-1.
    task automatic profile_b(input logic op);
        for (int c = 1; c <= 11; c++) begin
            check("b_lat_g", int'(lat_g_b), int'(c >= 3 && c <= 5));
            check("b_lat_s", int'(lat_s_b), int'(c <= 7 && op));
            check("b_lat_r", int'(lat_r_b), int'(c <= 7 && !op));
            check("b_done", int'(done_valid_b), int'(c == 10));
            check("b_ready", int'(req_ready_b), int'(c == 11));
            if (c < 11) @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic last_op;
        int n;
        req_valid_a = 1'b0; req_op_a = 1'b0;
        req_valid_b = 1'b0; req_op_b = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_lat_g", int'(lat_g_a), 0);
        check("rst_lat_s", int'(lat_s_a), 0);
        check("rst_lat_r", int'(lat_r_a), 0);
        check("rst_done_valid", int'(done_valid_a), 0);
        check("rst_done_err", int'(done_err_a), 0);
        check("rst_err_cnt", int'(err_cnt_a), 0);
        check("rst_req_ready", int'(req_ready_a), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Set with default timing
        issue_a(1'b1, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            check("t1_lat_s", int'(lat_s_a), int'(c <= 4));
            check("t1_lat_r", int'(lat_r_a), 0);
            check("t1_lat_g", int'(lat_g_a), int'(c == 2 || c == 3));
            check("t1_done", int'(done_valid_a), int'(c == 7));
            check("t1_ready", int'(req_ready_a), int'(c == 8));
            if (c < 8) @(negedge clk);
        end
        check("t1_latch_q", int'(q_a), 1);
        drain_a();
        issue_a(1'b0, 1'b0);
        drain_a();
        check("t1_reset_q", int'(q_a), 0);

        // Reset then set with 2/3/2 timing
        issue_b(1'b0);
        profile_b(1'b0);
        check("b_q_after_reset", int'(q_b), 0);
        issue_b(1'b1);
        profile_b(1'b1);
        check("b_q_after_set", int'(q_b), 1);

        // Busy-ignore: valid held high with toggling op
        req_valid_a = 1'b1;
        req_op_a = 1'b0;
        exp_err_a.push_back(1'b0);
        exp_cnt_a.push_back(cnt_model_a);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c < 8) req_op_a = c[0];
            check("busy_ready", int'(req_ready_a), int'(c == 8));
        end
        exp_err_a.push_back(1'b0);
        exp_cnt_a.push_back(cnt_model_a);
        @(negedge clk);
        req_valid_a = 1'b0;
        check("busy_second_accept", int'(req_ready_a), 0);
        drain_a();
        check("busy_q", int'(q_a), 1);

        // Stuck latch: every set fails, counter saturates
        stuck = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue_a(1'b1, 1'b1);
            drain_a();
            check("stuck_err_cnt", int'(err_cnt_a), i + 1);
        end
        for (int i = 0; i < 257; i++) issue_a(1'b1, 1'b1);
        drain_a();
        check("stuck_sat", int'(err_cnt_a), 255);
        stuck = 1'b0;

        // Reset mid-PULSE
        issue_a(1'b0, 1'b0);
        n = 0;
        while (!lat_g_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_reached_pulse", int'(lat_g_a), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_lat_g", int'(lat_g_a), 0);
        check("mid_lat_s", int'(lat_s_a), 0);
        check("mid_lat_r", int'(lat_r_a), 0);
        exp_err_a.delete();
        exp_cnt_a.delete();
        cnt_model_a = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_req_ready", int'(req_ready_a), 1);
        check("mid_err_cnt", int'(err_cnt_a), 0);

        // Random sweep
        last_op = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            last_op = 1'($urandom_range(0, 1));
            issue_a(last_op, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain_a();
        check("sweep_q", int'(q_a), int'(last_op));
        check("sweep_err_cnt", int'(err_cnt_a), 0);
        check("excl_and_glitch", excl_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
